// File: rtl/uart_rx_framer.sv
// Parametrised UART receiver: oversampled start/data/parity/stop framing into a one-entry
// valid/ready holding register. Define UART_RX_MAJORITY_EN for a 2-of-3 vote per bit sample.
//
// state  | meaning
// IDLE   | line idle; a low tick starts a frame once the line has been seen high
// START  | confirming the start bit at mid-bit (false start returns to IDLE)
// DATA   | shifting in DATA_BITS data bits, LSB first
// PARITY | comparing the parity bit against the received data
// STOP   | sampling STOP_BITS stop bits; last sample raises done and re-arms
module uart_rx_framer #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    input  logic                 i_tick,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overrun,
    output logic                 o_busy
);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMP = MID + 1;
`else
    localparam int SAMP = MID;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [3:0]             bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   arm_q, arm_d;
    logic                   done_q, done_d;
    logic [DATA_BITS-1:0]   hold_data_q, hold_data_d;
    logic                   hold_perr_q, hold_perr_d;
    logic                   hold_ferr_q, hold_ferr_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic                   rx_s, at_samp, sample;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]             vote_q, vote_d;
`endif

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign at_samp = (tcnt_q == TW'(SAMP));
`ifdef UART_RX_MAJORITY_EN
    assign sample  = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
    assign sample  = rx_s;
`endif

    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], i_rx};
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        arm_d       = arm_q;
        done_d      = 1'b0;
        hold_data_d = hold_data_q;
        hold_perr_d = hold_perr_q;
        hold_ferr_d = hold_ferr_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
`ifdef UART_RX_MAJORITY_EN
        vote_d      = vote_q;
`endif
        if (i_tick) begin
            tcnt_d = (tcnt_q == TW'(OVERSAMPLE - 1)) ? '0 : tcnt_q + 1'b1;
`ifdef UART_RX_MAJORITY_EN
            if (tcnt_q == TW'(MID - 1)) vote_d[0] = rx_s;
            if (tcnt_q == TW'(MID))     vote_d[1] = rx_s;
`endif
            case (state_q)
                S_IDLE: begin
                    tcnt_d = '0;
                    if (rx_s) arm_d = 1'b1;
                    if (!rx_s && arm_q) state_d = S_START;
                end
                S_START: if (at_samp) begin
                    if (!sample) begin
                        state_d = S_DATA;
                        bcnt_d  = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: if (at_samp) begin
                    shift_d = {sample, shift_q[DATA_BITS-1:1]};
                    if (bcnt_q == 4'(DATA_BITS - 1)) begin
                        bcnt_d  = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                S_PARITY: if (at_samp) begin
                    perr_d  = sample != ((PARITY == 1) ? ^shift_q : ~^shift_q);
                    state_d = S_STOP;
                end
                S_STOP: if (at_samp) begin
                    if (!sample) ferr_d = 1'b1;
                    if (bcnt_q == 4'(STOP_BITS - 1)) begin
                        // A low final stop bit (break) must see the line high before re-arming.
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        arm_d   = sample;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (done_q) begin
            if (!valid_q || i_ready) begin
                hold_data_d = shift_q;
                hold_perr_d = perr_q;
                hold_ferr_d = ferr_q;
                valid_d     = 1'b1;
                if (valid_q) overrun_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d     = 1'b0;
            overrun_d   = 1'b0;
            hold_perr_d = 1'b0;
            hold_ferr_d = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            sync_q      <= '1;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            arm_q       <= 1'b1;
            done_q      <= 1'b0;
            hold_data_q <= '0;
            hold_perr_q <= 1'b0;
            hold_ferr_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            vote_q      <= 2'b11;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            arm_q       <= arm_d;
            done_q      <= done_d;
            hold_data_q <= hold_data_d;
            hold_perr_q <= hold_perr_d;
            hold_ferr_q <= hold_ferr_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
`ifdef UART_RX_MAJORITY_EN
            vote_q      <= vote_d;
`endif
        end
    end

    assign o_data       = hold_data_q;
    assign o_parity_err = hold_perr_q;
    assign o_frame_err  = hold_ferr_q;
    assign o_valid      = valid_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = busy_q;
endmodule
